// File: rtl/oe_sort_pkg.sv
// oe_sort_pkg: state encoding and lane-slicing helpers for the odd-even transposition sorter
package oe_sort_pkg;

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/oe_cmp_swap.sv
// oe_cmp_swap: compare-exchange of one adjacent (key, idx) pair; strict compare keeps equal keys in place
module oe_cmp_swap #(
    parameter int W      = 16,
    parameter int IDX_W  = 3,
    parameter bit SIGNED = 0
) (
    input  logic             desc,
    input  logic [W-1:0]     a_key,
    input  logic [W-1:0]     b_key,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [IDX_W-1:0] b_idx,
    output logic [W-1:0]     x_key,
    output logic [W-1:0]     y_key,
    output logic [IDX_W-1:0] x_idx,
    output logic [IDX_W-1:0] y_idx
);
    logic gt, lt, swap;
    always_comb begin
        gt    = SIGNED ? ($signed(a_key) > $signed(b_key)) : (a_key > b_key);
        lt    = SIGNED ? ($signed(a_key) < $signed(b_key)) : (a_key < b_key);
        swap  = desc ? lt : gt;
        x_key = swap ? b_key : a_key;
        y_key = swap ? a_key : b_key;
        x_idx = swap ? b_idx : a_idx;
        y_idx = swap ? a_idx : b_idx;
    end
endmodule

// File: rtl/oe_sort_n.sv
// oe_sort_n: N-lane odd-even transposition sorter, one phase per cycle, carrying original lane indices
module oe_sort_n
    import oe_sort_pkg::*;
#(
    parameter int N        = 8,
    parameter int W        = 16,
    parameter bit SIGNED   = 0,
    localparam int IDX_W   = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic               in_desc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*W-1:0]     out_data,
    output logic [N*IDX_W-1:0] out_idx,
    output logic               busy
);
    state_t state, state_d;
    logic [IDX_W-1:0] phase;
    logic             desc;
    logic             last;
    logic [W-1:0]     key [N];
    logic [IDX_W-1:0] idx [N];
    logic [W-1:0]     ek [N];
    logic [W-1:0]     ok [N];
    logic [IDX_W-1:0] ei [N];
    logic [IDX_W-1:0] oi [N];

    assign last = phase == IDX_W'(N - 1);

    genvar e, o, l;
    for (e = 0; e < N / 2; e++) begin : g_even
        oe_cmp_swap #(.W(W), .IDX_W(IDX_W), .SIGNED(SIGNED)) u_cs (
            .desc  (desc),
            .a_key (key[2*e]),
            .b_key (key[2*e+1]),
            .a_idx (idx[2*e]),
            .b_idx (idx[2*e+1]),
            .x_key (ek[2*e]),
            .y_key (ek[2*e+1]),
            .x_idx (ei[2*e]),
            .y_idx (ei[2*e+1])
        );
    end

    // end lanes sit out the odd phase
    assign ok[0]   = key[0];
    assign oi[0]   = idx[0];
    assign ok[N-1] = key[N-1];
    assign oi[N-1] = idx[N-1];
    for (o = 0; o < N / 2 - 1; o++) begin : g_odd
        oe_cmp_swap #(.W(W), .IDX_W(IDX_W), .SIGNED(SIGNED)) u_cs (
            .desc  (desc),
            .a_key (key[2*o+1]),
            .b_key (key[2*o+2]),
            .a_idx (idx[2*o+1]),
            .b_idx (idx[2*o+2]),
            .x_key (ok[2*o+1]),
            .y_key (ok[2*o+2]),
            .x_idx (oi[2*o+1]),
            .y_idx (oi[2*o+2])
        );
    end

    for (l = 0; l < N; l++) begin : g_out
        assign out_data[lane_lo(l, W) +: W]         = key[l];
        assign out_idx[lane_lo(l, IDX_W) +: IDX_W]  = idx[l];
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = SORT;
            SORT:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            desc  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                key[i] <= '0;
                idx[i] <= '0;
            end
        end else if (state == IDLE && in_valid) begin
            phase <= '0;
            desc  <= in_desc;
            for (int i = 0; i < N; i++) begin
                key[i] <= in_data[lane_lo(i, W) +: W];
                idx[i] <= IDX_W'(i);
            end
        end else if (state == SORT) begin
            phase <= last ? phase : phase + 1'b1;
            for (int i = 0; i < N; i++) begin
                key[i] <= phase[0] ? ok[i] : ek[i];
                idx[i] <= phase[0] ? oi[i] : ei[i];
            end
        end
    end
endmodule

// File: tb/tb_oe_sort_n.sv
// tb_oe_sort_n: scoreboard bench; stable-sort reference model feeds queues checked by per-DUT monitors
module tb_oe_sort_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, in_desc = 1'b0, out_ready = 1'b0;
    logic [63:0]  in_data = '0;
    logic         in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic [63:0]  out_data0, out_data1;
    logic [7:0]   out_idx0, out_idx1;

    logic         in_valid2 = 1'b0, in_desc2 = 1'b0, out_ready2 = 1'b0;
    logic [127:0] in_data2 = '0;
    logic         in_ready2, out_valid2, busy2;
    logic [127:0] out_data2;
    logic [23:0]  out_idx2;

    oe_sort_n #(.N(4), .W(16), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_desc(in_desc), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_idx(out_idx0), .busy(busy0)
    );
    oe_sort_n #(.N(4), .W(16), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_desc(in_desc), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_idx(out_idx1), .busy(busy1)
    );
    oe_sort_n #(.N(8), .W(16), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .in_desc(in_desc2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_idx(out_idx2), .busy(busy2)
    );

    typedef struct { logic [127:0] d; logic [23:0] i; } exp_t;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2, ex;
    int checks = 0, errors = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endfunction

    function automatic void miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output with empty scoreboard", name);
    endfunction

    // stable reference sort by plain insertion on numeric key values
    function automatic void ref_sort(input int n, input int w, input int iw, input bit sgn, input bit dsc,
                                     input logic [127:0] d, output logic [127:0] od, output logic [23:0] oi);
        longint v [8];
        int ix [8];
        longint tv;
        int ti;
        logic [127:0] k;
        logic [127:0] mask = (128'd1 << w) - 128'd1;
        for (int i = 0; i < n; i++) begin
            k = (d >> (i * w)) & mask;
            v[i] = longint'(k[63:0]);
            if (sgn && k[w-1]) v[i] -= longint'(1) << w;
            ix[i] = i;
        end
        for (int i = 1; i < n; i++)
            for (int j = i; j > 0 && (dsc ? v[j] > v[j-1] : v[j] < v[j-1]); j--) begin
                tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
                ti = ix[j]; ix[j] = ix[j-1]; ix[j-1] = ti;
            end
        od = '0;
        oi = '0;
        for (int i = 0; i < n; i++) begin
            od |= (128'(v[i]) & mask) << (i * w);
            oi |= 24'(ix[i]) << (i * iw);
        end
    endfunction

    always @(negedge clk) if (!rst) begin
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) miss("u0");
            else begin
                e0 = q0.pop_front();
                chk("u0 data", 128'(out_data0), e0.d);
                chk("u0 idx", 128'(out_idx0), 128'(e0.i));
            end
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) miss("u1");
            else begin
                e1 = q1.pop_front();
                chk("u1 data", 128'(out_data1), e1.d);
                chk("u1 idx", 128'(out_idx1), 128'(e1.i));
            end
        end
        if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) miss("u2");
            else begin
                e2 = q2.pop_front();
                chk("u2 data", out_data2, e2.d);
                chk("u2 idx", 128'(out_idx2), 128'(e2.i));
            end
        end
    end

    task automatic push_a(input logic [63:0] d0, input logic [7:0] i0, input logic [63:0] d1, input logic [7:0] i1);
        ex.d = 128'(d0); ex.i = 24'(i0); q0.push_back(ex);
        ex.d = 128'(d1); ex.i = 24'(i1); q1.push_back(ex);
    endtask

    task automatic wait_a(input int lat);
        int n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("u0 latency", 128'(n), 128'(lat));
        chk("u1 valid with u0", 128'(out_valid1), 128'(out_valid0));
    endtask

    task automatic drain_a(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_a(input logic [63:0] d, input logic dsc, input logic [63:0] d0, input logic [7:0] i0,
                         input logic [63:0] d1, input logic [7:0] i1, input int hold);
        chk("u0 in_ready idle", 128'(in_ready0), 128'(1));
        push_a(d0, i0, d1, i1);
        in_data = d; in_desc = dsc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
        wait_a(4);
        drain_a(hold);
    endtask

    task automatic run_c(input logic [127:0] d, input logic dsc, input int hold);
        logic [127:0] rd;
        logic [23:0] ri;
        int n = 0;
        ref_sort(8, 16, 3, 1'b0, dsc, d, rd, ri);
        ex.d = rd; ex.i = ri; q2.push_back(ex);
        chk("u2 in_ready idle", 128'(in_ready2), 128'(1));
        in_data2 = d; in_desc2 = dsc; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        while (!out_valid2 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("u2 latency", 128'(n), 128'(8));
        repeat (hold) begin @(posedge clk); #1; end
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    logic [63:0]  rd;
    logic [127:0] r0d, r1d, wd;
    logic [23:0]  r0i, r1i;
    logic         rdsc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(in_ready0), 128'(1));
        chk("reset out_valid", 128'(out_valid0), 128'(0));
        chk("reset busy", 128'(busy0), 128'(0));
        chk("reset out_data", 128'(out_data0), 128'(0));
        chk("reset out_idx", 128'(out_idx0), 128'(0));
        rst = 1'b0;

        run_a({16'd1, 16'd7, 16'd3, 16'd9}, 1'b0, {16'd9, 16'd7, 16'd3, 16'd1}, {2'd0, 2'd2, 2'd1, 2'd3},
              {16'd9, 16'd7, 16'd3, 16'd1}, {2'd0, 2'd2, 2'd1, 2'd3}, 0);
        run_a({16'd1, 16'd7, 16'd3, 16'd9}, 1'b1, {16'd1, 16'd3, 16'd7, 16'd9}, {2'd3, 2'd1, 2'd2, 2'd0},
              {16'd1, 16'd3, 16'd7, 16'd9}, {2'd3, 2'd1, 2'd2, 2'd0}, 1);
        run_a({16'd2, 16'd5, 16'd2, 16'd5}, 1'b0, {16'd5, 16'd5, 16'd2, 16'd2}, {2'd2, 2'd0, 2'd3, 2'd1},
              {16'd5, 16'd5, 16'd2, 16'd2}, {2'd2, 2'd0, 2'd3, 2'd1}, 0);
        run_a({16'h0000, 16'h8000, 16'h0002, 16'hFFFF}, 1'b0,
              {16'hFFFF, 16'h8000, 16'h0002, 16'h0000}, {2'd0, 2'd2, 2'd1, 2'd3},
              {16'h0002, 16'h0000, 16'hFFFF, 16'h8000}, {2'd1, 2'd3, 2'd0, 2'd2}, 2);

        // stall in DONE while a new job is already being offered
        push_a({16'd9, 16'd7, 16'd3, 16'd1}, {2'd0, 2'd2, 2'd1, 2'd3},
               {16'd9, 16'd7, 16'd3, 16'd1}, {2'd0, 2'd2, 2'd1, 2'd3});
        in_data = {16'd1, 16'd7, 16'd3, 16'd9}; in_desc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_a(4);
        in_data = {16'd10, 16'd40, 16'd20, 16'd30}; in_desc = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall out_valid", 128'(out_valid0), 128'(1));
            chk("stall out_data", 128'(out_data0), 128'({16'd9, 16'd7, 16'd3, 16'd1}));
            chk("stall in_ready", 128'(in_ready0), 128'(0));
        end
        push_a({16'd10, 16'd20, 16'd30, 16'd40}, {2'd3, 2'd1, 2'd0, 2'd2},
               {16'd10, 16'd20, 16'd30, 16'd40}, {2'd3, 2'd1, 2'd0, 2'd2});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handshake edge in_ready", 128'(in_ready0), 128'(1));
        chk("handshake edge busy", 128'(busy0), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next job taken", 128'(busy0), 128'(1));
        wait_a(4);
        drain_a(0);

        // reset while phase 2 is pending
        in_data = {16'd11, 16'd22, 16'd33, 16'd44}; in_desc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid-sort busy", 128'(busy0), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-rst in_ready", 128'(in_ready0), 128'(1));
        chk("post-rst out_valid", 128'(out_valid0), 128'(0));
        chk("post-rst busy", 128'(busy0), 128'(0));
        chk("post-rst out_data", 128'(out_data0), 128'(0));
        chk("post-rst out_idx", 128'(out_idx0), 128'(0));
        run_a({16'd2, 16'd3, 16'd1, 16'd4}, 1'b0, {16'd4, 16'd3, 16'd2, 16'd1}, {2'd0, 2'd2, 2'd3, 2'd1},
              {16'd4, 16'd3, 16'd2, 16'd1}, {2'd0, 2'd2, 2'd3, 2'd1}, 0);

        for (int j = 0; j < 40; j++) begin
            for (int l = 0; l < 4; l++)
                rd[l*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            rdsc = 1'($urandom_range(0, 1));
            ref_sort(4, 16, 2, 1'b0, rdsc, 128'(rd), r0d, r0i);
            ref_sort(4, 16, 2, 1'b1, rdsc, 128'(rd), r1d, r1i);
            run_a(rd, rdsc, r0d[63:0], r0i[7:0], r1d[63:0], r1i[7:0], $urandom_range(0, 3));
        end

        for (int j = 0; j < 30; j++) begin
            for (int l = 0; l < 8; l++)
                wd[l*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            run_c(wd, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        chk("q0 drained", 128'(q0.size()), 128'(0));
        chk("q1 drained", 128'(q1.size()), 128'(0));
        chk("q2 drained", 128'(q2.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
